mem_port_arbiter: RTL

// - Shares one single-ported memory between the fetch stage (instruction reads) and the

---
 rtl/mem_arb_pkg.sv | 25 ++
 rtl/mem_port_arbiter_sat_counter.sv | 25 ++
 rtl/mem_port_arbiter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and grant selection for the fetch/data memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_BUSY_I = 2'd1,
        ARB_BUSY_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_D = 1'b0,
        REQ_I = 1'b1
    } req_id_t;

    // Ties go to the favoured side; otherwise whoever is eligible wins.
    function automatic req_id_t next_grant(input logic dElig, input logic iElig,
                                           input req_id_t favoured);
        req_id_t winner;
        if (dElig && iElig) winner = favoured;
        else if (dElig)     winner = REQ_D;
        else                winner = REQ_I;
        return winner;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; used for the arbitration conflict count.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_inc && (r_cnt != {CNT_W{1'b1}}))
            r_cnt <= r_cnt + CNT_W'(1);
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and the data stage.
// Define MEM_ARB_RR_EN for round-robin ties; default build gives data fixed priority.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    output logic [DATA_W-1:0] o_if_rdata,
    output logic              o_if_ack,
    input  logic              i_d_req,
    input  logic              i_d_we,
    input  logic [ADDR_W-1:0] i_d_addr,
    input  logic [DATA_W-1:0] i_d_wdata,
    output logic [DATA_W-1:0] o_d_rdata,
    output logic              o_d_ack,
    output logic              o_m_req,
    output logic              o_m_we,
    output logic [ADDR_W-1:0] o_m_addr,
    output logic [DATA_W-1:0] o_m_wdata,
    input  logic [DATA_W-1:0] i_m_rdata,
    input  logic              i_m_ready,
    output logic [CNT_W-1:0]  o_conflict_cnt
);

    arb_state_t        r_state;
    logic              r_mReq;
    logic              r_mWe;
    logic [ADDR_W-1:0] r_mAddr;
    logic [DATA_W-1:0] r_mWdata;
    logic              r_ifAck;
    logic              r_dAck;
    logic [DATA_W-1:0] r_ifRdata;
    logic [DATA_W-1:0] r_dRdata;

    logic    w_busy;
    logic    w_done;
    logic    w_arbitrate;
    logic    w_ifElig;
    logic    w_dElig;
    logic    w_anyElig;
    logic    w_conflict;
    req_id_t w_favoured;
    req_id_t w_winner;

`ifdef MEM_ARB_RR_EN
    req_id_t r_ptr;
    assign w_favoured = r_ptr;
`else
    assign w_favoured = REQ_D;
`endif

    // A side's request is stale while it is being completed or while its ack is out.
    always_comb begin
        w_busy      = (r_state != ARB_IDLE);
        w_done      = w_busy && i_m_ready;
        w_arbitrate = !w_busy || w_done;
        w_ifElig    = i_if_req && !r_ifAck && !(w_done && (r_state == ARB_BUSY_I));
        w_dElig     = i_d_req && !r_dAck && !(w_done && (r_state == ARB_BUSY_D));
        w_anyElig   = w_ifElig || w_dElig;
        w_winner    = next_grant(w_dElig, w_ifElig, w_favoured);
        w_conflict  = ((r_state == ARB_BUSY_I) && i_d_req)
                   || ((r_state == ARB_BUSY_D) && i_if_req)
                   || ((r_state == ARB_IDLE) && i_if_req && i_d_req);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ARB_IDLE;
            r_mReq    <= 1'b0;
            r_mWe     <= 1'b0;
            r_mAddr   <= '0;
            r_mWdata  <= '0;
            r_ifAck   <= 1'b0;
            r_dAck    <= 1'b0;
            r_ifRdata <= '0;
            r_dRdata  <= '0;
`ifdef MEM_ARB_RR_EN
            r_ptr     <= REQ_D;
`endif
        end else begin
            r_ifAck <= w_done && (r_state == ARB_BUSY_I);
            r_dAck  <= w_done && (r_state == ARB_BUSY_D);
            if (w_done) begin
                if (r_state == ARB_BUSY_I) r_ifRdata <= i_m_rdata;
                else                       r_dRdata  <= i_m_rdata;
            end
            // Granting in the completion cycle keeps m_req high with no idle bubble.
            if (w_arbitrate) begin
                if (w_anyElig) begin
                    r_mReq <= 1'b1;
                    if (w_winner == REQ_D) begin
                        r_state  <= ARB_BUSY_D;
                        r_mWe    <= i_d_we;
                        r_mAddr  <= i_d_addr;
                        r_mWdata <= i_d_wdata;
                    end else begin
                        r_state  <= ARB_BUSY_I;
                        r_mWe    <= 1'b0;
                        r_mAddr  <= i_if_addr;
                        r_mWdata <= '0;
                    end
`ifdef MEM_ARB_RR_EN
                    r_ptr <= (w_winner == REQ_D) ? REQ_I : REQ_D;
`endif
                end else begin
                    r_state <= ARB_IDLE;
                    r_mReq  <= 1'b0;
                end
            end
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_conflictCnt (
        .clk   (clk),
        .reset (reset),
        .i_inc (w_conflict),
        .i_clr (1'b0),
        .o_cnt (o_conflict_cnt)
    );

    assign o_m_req    = r_mReq;
    assign o_m_we     = r_mWe;
    assign o_m_addr   = r_mAddr;
    assign o_m_wdata  = r_mWdata;
    assign o_if_ack   = r_ifAck;
    assign o_d_ack    = r_dAck;
    assign o_if_rdata = r_ifRdata;
    assign o_d_rdata  = r_dRdata;

endmodule
